// File: rtl/jpu_uart_rx.sv
// jpu_uart_rx: 8N1 UART receiver with a one-entry valid/ready output buffer.
// Frame errors and overruns are reported as single-cycle registered pulses.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for rxd_s low (start edge)
// S_START | timing half a bit to the start-bit midpoint, glitch check
// S_DATA  | sampling 8 data bits, LSB first, one per bit period
// S_STOP  | timing one bit period to the stop-bit midpoint
// S_BREAK | stop bit was low; waiting for the line to return high
module jpu_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("jpu_uart_rx: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          sync1_q;
  logic          sync2_q;
  logic          rxd_s;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          ovr_q;
  logic          sample;
  logic          done_d;
  logic          ferr_d;

  assign rxd_s = sync2_q;

  // Two-flop synchronizer for the asynchronous pin; resets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // Stop-bit sample decides between a delivered byte and a framing error.
  always_comb begin
    sample = (cnt_q == '0);
    done_d = (state_q == S_STOP) && sample && rxd_s;
    ferr_d = (state_q == S_STOP) && sample && !rxd_s;
  end

  // Receive FSM: down-counter times each sample point, terminal count = sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            cnt_q   <= HALF_LOAD;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (sample) begin
            if (rxd_s) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q   <= BIT_LOAD;
              idx_q   <= 3'd0;
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DATA: begin
          if (sample) begin
            shift_q[idx_q] <= rxd_s;
            cnt_q          <= BIT_LOAD;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_STOP: begin
          if (sample) begin
            state_q <= rxd_s ? S_IDLE : S_BREAK;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_BREAK: begin
          if (rxd_s) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // One-entry output buffer plus registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovr_q  <= 1'b0;
      if (done_d) begin
        // A consumer accepting the old byte on this cycle frees the slot.
        if (!valid_q || rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_jpu_uart_rx.sv
// Testbench for jpu_uart_rx with CLKS_PER_BIT = 16.
module tb_jpu_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // pin fall -> 2 sync cycles -> start mid -> 9 bit periods -> +1 register
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         vis;
    logic [7:0] data;
    logic       ok;
  } ev_t;
  ev_t evq[$];

  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] m_data;

  int   ready_mode;
  logic ready_man;
  logic rnd_ready;
  bit   mon_en;
  int   ov_cnt, fe_cnt;
  logic [7:0] rcvq[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[6];

  assign rx_ready = (ready_mode == 1) ? 1'b1 :
                    (ready_mode == 2) ? rnd_ready : ready_man;

  jpu_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) tick();
  endtask

  // Sends one frame starting now; the model learns when its result appears.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    evq.push_back('{cyc + LAT, d, stop_b});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  task automatic consume();
    tick();
    ready_man = 1'b1;
    tick();
    ready_man = 1'b0;
    tick();
  endtask

  // Reference model: frame results arrive at their computed cycle and go
  // through a one-entry buffer governed by the consumer handshake.
  initial begin
    logic       done;
    logic [7:0] ddata;
    m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
    forever begin
      @(posedge clk);
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (rst) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        evq.delete();
      end else begin
        done  = 1'b0;
        ddata = 8'h00;
        if (evq.size() > 0 && evq[0].vis == cyc + 1) begin
          if (evq[0].ok) begin
            done  = 1'b1;
            ddata = evq[0].data;
          end else begin
            m_ferr = 1'b1;
          end
          evq.delete(0);
        end
        if (done) begin
          if (!m_valid || rx_ready) begin
            m_valid = 1'b1;
            m_data  = ddata;
          end else begin
            m_ovr = 1'b1;
          end
        end else if (m_valid && rx_ready) begin
          m_valid = 1'b0;
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model, plus event counters.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("mon_valid", rx_valid, m_valid);
        check("mon_data", rx_data, m_data);
        check("mon_frame_err", frame_err, m_ferr);
        check("mon_overrun", overrun, m_ovr);
      end
      if (overrun) ov_cnt++;
      if (frame_err) fe_cnt++;
      if (rx_valid && rx_ready) rcvq.push_back(rx_data);
    end
  end

  initial begin
    rnd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int k;
    int ov0, fe0;
    logic [7:0] exp_stream[3];
    logic [7:0] d;
    logic good;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'h55, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};

    rst = 1'b1; rxd = 1'b1; ready_mode = 0; ready_man = 1'b0;
    mon_en = 1'b0; ov_cnt = 0; fe_cnt = 0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_data", rx_data, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (4) tick();

    // Table-driven single frames with the consumer stalled.
    for (int i = 0; i < 6; i++) begin
      k   = cyc;
      fe0 = fe_cnt;
      fork
        send_frame(vecs[i].data, vecs[i].stop);
        begin
          wait_until(k + LAT);
          @(negedge clk);
          check("vec_valid", rx_valid, vecs[i].exp_valid);
          check("vec_data", rx_data, vecs[i].exp_data);
          check("vec_frame_err", frame_err, vecs[i].exp_ferr);
        end
      join
      if (!vecs[i].stop) begin
        repeat (40) tick();
        rxd = 1'b1;
      end
      repeat (4) tick();
      check("vec_ferr_count", fe_cnt - fe0, vecs[i].exp_ferr);
      if (vecs[i].exp_valid) begin
        @(negedge clk);
        check("vec_hold", rx_valid, 1'b1);
        tick();
        ready_man = 1'b1;
        tick();
        ready_man = 1'b0;
        @(negedge clk);
        check("vec_drop", rx_valid, 1'b0);
        tick();
      end
    end

    // Glitch: 4 low cycles, then a real frame whose start must still be caught.
    k   = cyc;
    fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (5) tick();
    fork
      send_frame(8'hC7, 1'b1);
      begin
        wait_until(k + 9 + LAT);
        @(negedge clk);
        check("glitch_valid", rx_valid, 1'b1);
        check("glitch_data", rx_data, 8'hC7);
      end
    join
    check("glitch_no_ferr", fe_cnt - fe0, 0);
    consume();

    // Overrun: two frames back-to-back, consumer stalled.
    k   = cyc;
    ov0 = ov_cnt;
    fork
      begin
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
      end
      begin
        wait_until(k + FRAME + LAT);
        @(negedge clk);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_data", rx_data, 8'h12);
        check("ovr_valid", rx_valid, 1'b1);
      end
    join
    repeat (20) tick();
    check("ovr_count", ov_cnt - ov0, 1);
    check("ovr_data_held", rx_data, 8'h12);
    consume();

    // Streaming with the consumer always ready.
    ready_mode = 1;
    rcvq.delete();
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    exp_stream[0] = 8'h00; exp_stream[1] = 8'hFF; exp_stream[2] = 8'h81;
    for (int i = 0; i < 3; i++) send_frame(exp_stream[i], 1'b1);
    repeat (5) tick();
    check("stream_count", rcvq.size(), 3);
    for (int i = 0; i < rcvq.size() && i < 3; i++) check("stream_byte", rcvq[i], exp_stream[i]);
    check("stream_no_ovr", ov_cnt - ov0, 0);
    check("stream_no_ferr", fe_cnt - fe0, 0);
    ready_mode = 0;
    repeat (3) tick();

    // Reset during data bit 3 of 0xF0 while a byte is pending.
    send_frame(8'h99, 1'b1);
    fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (CPB) tick();
    repeat (3 * CPB) tick();
    repeat (HALF) tick();
    rst = 1'b1;
    rxd = 1'b1;
    tick();
    @(negedge clk);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    repeat (40) tick();
    check("rst_no_valid", rx_valid, 1'b0);
    check("rst_no_ferr", fe_cnt - fe0, 0);
    k = cyc;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        wait_until(k + LAT);
        @(negedge clk);
        check("post_rst_valid", rx_valid, 1'b1);
        check("post_rst_data", rx_data, 8'h5A);
      end
    join
    consume();

    // Randomized frames, gaps, bad stop bits and consumer back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 50; i++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      send_frame(d, good);
      if (!good) begin
        repeat ($urandom_range(0, 30)) tick();
        rxd = 1'b1;
        repeat (2 + $urandom_range(0, 10)) tick();
      end else begin
        repeat ($urandom_range(0, 12)) tick();
      end
    end
    ready_mode = 0;
    repeat (200) tick();
    check("model_drained", evq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
